// File: rtl/skolem_pkg.sv
// Shared types and default widths for the Skolem witness search block.
package skolem_pkg;

  localparam int SKOLEM_NUM_VARS = 25;
  localparam int SKOLEM_NUM_Y    = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } skolem_state_e;

endpackage

// File: rtl/skolem_cand_ctr.sv
// Existential candidate counter: synchronous clear, increment, all-ones detect.
module skolem_cand_ctr #(
  parameter int NUM_Y = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [NUM_Y-1:0] y,
  output logic             last
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      y <= '0;
    else if (clr) y <= '0;
    else if (inc) y <= y + NUM_Y'(1);
  end

  assign last = &y;

endmodule

// File: rtl/skolem_witness_search.sv
// Walks Y candidates in ascending order through an external checker and reports the first hit.
// Optional tries counter and out_tries port enabled by defining SKOLEM_STATS_EN.
module skolem_witness_search
  import skolem_pkg::*;
#(
  parameter int NUM_VARS = SKOLEM_NUM_VARS,
  parameter int NUM_Y    = SKOLEM_NUM_Y,
  localparam int NUM_X   = NUM_VARS - NUM_Y
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [NUM_X-1:0]    in_x,
  output logic [NUM_VARS-1:0] f_vec,
  input  logic                f_out,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [NUM_Y-1:0]    out_y,
  output logic                out_sat
`ifdef SKOLEM_STATS_EN
  ,
  output logic [NUM_Y:0]      out_tries
`endif
);

  // state  | meaning
  // IDLE   | waiting for a query, in_ready high
  // SEARCH | presenting candidate y_cnt to the checker, sampling f_out
  // DONE   | result held on out_* until out_ready

  skolem_state_e    state;
  logic [NUM_X-1:0] x_reg;
  logic [NUM_Y-1:0] y_cnt;
  logic [NUM_Y-1:0] y_nxt;
  logic             y_last;
  logic             cnt_clr;
  logic             cnt_inc;

  assign cnt_clr = (state == IDLE) & in_valid;
  assign cnt_inc = (state == SEARCH) & ~f_out & ~y_last;
  assign y_nxt   = y_cnt + NUM_Y'(1);

  skolem_cand_ctr #(.NUM_Y(NUM_Y)) u_cand_ctr (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .inc  (cnt_inc),
    .y    (y_cnt),
    .last (y_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      x_reg     <= '0;
      f_vec     <= '0;
      out_y     <= '0;
      out_sat   <= 1'b0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
`ifdef SKOLEM_STATS_EN
      out_tries <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            x_reg    <= in_x;
            f_vec    <= {{NUM_Y{1'b0}}, in_x};
            in_ready <= 1'b0;
            state    <= SEARCH;
          end
        end
        SEARCH: begin
          // A hit on the all-ones candidate still counts as a witness.
          if (f_out || y_last) begin
            out_y     <= f_out ? y_cnt : '0;
            out_sat   <= f_out;
            out_valid <= 1'b1;
            state     <= DONE;
`ifdef SKOLEM_STATS_EN
            out_tries <= {1'b0, y_cnt} + (NUM_Y+1)'(1);
`endif
          end else begin
            f_vec <= {y_nxt, x_reg};
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_skolem_witness_search.sv
// Scoreboard bench: driver pushes expected results, a negedge monitor pops and compares.
module tb_skolem_witness_search;
  localparam int NV = 25;
  localparam int NY = 4;
  localparam int NX = NV - NY;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [NX-1:0] in_x = '0;
  logic [NV-1:0] f_vec;
  logic          f_out;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [NY-1:0] out_y;
  logic          out_sat;
`ifdef SKOLEM_STATS_EN
  logic [NY:0]   out_tries;
`endif

  skolem_witness_search #(.NUM_VARS(NV), .NUM_Y(NY)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .f_vec     (f_vec),
    .f_out     (f_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_sat   (out_sat)
`ifdef SKOLEM_STATS_EN
    ,
    .out_tries (out_tries)
`endif
  );

  always #5 clk = ~clk;

  // Checker model: 0 = (y == x[3:0]), 1 = const 0, 2 = const 1, 3 = (y == 0xF)
  int mode = 0;
  logic [3:0] fy;
  assign fy = f_vec[NV-1:NX];
  always_comb begin
    f_out = 1'b0;
    case (mode)
      0: f_out = (fy == f_vec[3:0]);
      1: f_out = 1'b0;
      2: f_out = 1'b1;
      default: f_out = (fy == 4'hF);
    endcase
  end

  typedef struct {
    logic [3:0] y;
    logic       sat;
    int         tries;
    int         lat;
    string      name;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int acc_cyc = 0;
  logic prev_v = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (in_valid && in_ready) acc_cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (out_valid && !prev_v) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result out_y=%0h out_sat=%0b expected=none", out_y, out_sat);
      end else begin
        e = q.pop_front();
        chk({e.name, "_y"}, 32'(out_y), 32'(e.y));
        chk({e.name, "_sat"}, 32'(out_sat), 32'(e.sat));
        chk({e.name, "_latency"}, 32'(cyc - acc_cyc), 32'(e.lat));
`ifdef SKOLEM_STATS_EN
        chk({e.name, "_tries"}, 32'(out_tries), 32'(e.tries));
`endif
      end
    end
    prev_v = out_valid;
  end

  task automatic push(input logic [3:0] y, input logic sat, input int n, input string nm);
    exp_t t;
    t.y = y; t.sat = sat; t.tries = n; t.lat = n; t.name = nm;
    q.push_back(t);
  endtask

  task automatic send(input logic [NX-1:0] x, input int m);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      failures++;
      $display("FAIL accept_timeout in_ready=%0b expected=1", in_ready);
    end
    mode = m;
    in_x = x;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      failures++;
      $display("FAIL %s_timeout out_valid=%0b expected=1", nm, out_valid);
    end
  endtask

  task automatic finish_result(input string nm);
    wait_done(nm);
    @(negedge clk);
  endtask

  logic [NV-1:0] snap;

  initial begin
    #12;
    chk("rst_fvec", 32'(f_vec), 0);
    chk("rst_out_y", 32'(out_y), 0);
    chk("rst_out_sat", 32'(out_sat), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
`ifdef SKOLEM_STATS_EN
    chk("rst_tries", 32'(out_tries), 0);
`endif
    rst = 1'b0;

    // Case 1 and variants of the equality checker
    push(4'h5, 1'b1, 6, "c1");
    send(21'h000005, 0);
    finish_result("c1");
    push(4'h0, 1'b1, 1, "c1_y0");
    send(21'h012340, 0);
    finish_result("c1_y0");
    push(4'hC, 1'b1, 13, "c1_yc");
    send(21'h00AB3C, 0);
    finish_result("c1_yc");

    // Case 2: exhaustion
    push(4'h0, 1'b0, 16, "c2");
    send(21'h01ABCD, 1);
    wait_done("c2");
    chk("c2_fvec_y", 32'(f_vec[NV-1:NX]), 32'hF);
    chk("c2_fvec_x", 32'(f_vec[NX-1:0]), 32'h01ABCD);
    @(negedge clk);

    // Case 3: constant 1 and last-candidate-only hit
    push(4'h0, 1'b1, 1, "c3_const1");
    send(21'h000777, 2);
    finish_result("c3_const1");
    push(4'hF, 1'b1, 16, "c3_last");
    send(21'h000123, 3);
    finish_result("c3_last");

    // Case 4: backpressure with in_valid toggling
    out_ready = 1'b0;
    push(4'h5, 1'b1, 6, "c4");
    send(21'h000005, 0);
    wait_done("c4");
    snap = f_vec;
    for (int i = 0; i < 3; i++) begin
      in_valid = ~in_valid;
      in_x = 21'h000009;
      @(negedge clk);
      chk("c4_hold_valid", 32'(out_valid), 1);
      chk("c4_hold_ready", 32'(in_ready), 0);
      chk("c4_hold_y", 32'(out_y), 5);
      chk("c4_hold_sat", 32'(out_sat), 1);
      chk("c4_hold_fvec", 32'(f_vec), 32'(snap));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("c4_release_ready", 32'(in_ready), 1);
    chk("c4_release_valid", 32'(out_valid), 0);
    push(4'h3, 1'b1, 4, "c4_next");
    send(21'h000003, 0);
    finish_result("c4_next");

    // Case 5: async reset mid-search at y = 7
    send(21'h000042, 1);
    for (int i = 0; i < 40 && fy != 4'h7; i++) @(negedge clk);
    chk("c5_reached_y7", 32'(fy), 7);
    #2 rst = 1'b1;
    #1;
    chk("c5_rst_fvec", 32'(f_vec), 0);
    chk("c5_rst_out_y", 32'(out_y), 0);
    chk("c5_rst_out_sat", 32'(out_sat), 0);
    chk("c5_rst_out_valid", 32'(out_valid), 0);
    chk("c5_rst_in_ready", 32'(in_ready), 1);
    #4 rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("c5_no_result", 32'(out_valid), 0);
    push(4'h5, 1'b1, 6, "c5_after");
    send(21'h000005, 0);
    finish_result("c5_after");

    // Case 6: in_x changes during SEARCH are ignored
    push(4'h5, 1'b1, 6, "c6");
    send(21'h000005, 0);
    in_x = 21'h1FFFF0;
    @(negedge clk);
    chk("c6_fvec_x_mid", 32'(f_vec[NX-1:0]), 5);
    wait_done("c6");
    chk("c6_fvec_x_done", 32'(f_vec[NX-1:0]), 5);
    @(negedge clk);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
